// File: rtl/mem_exec_unit.sv
// mem_exec_unit: load/store execution unit with a single outstanding request.
// It takes one memory op from the reservation station and computes the
// effective address. It then issues one data-memory request, aligns and
// extends the load data, and holds the result for the CDB/ROB writeback path.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             pipeline flush; drops the op, drains any in-flight request
//   iss_*             issue handshake and operands from the mem reservation station
//   dmem_*            data-memory request (addr/masks/wdata) and response (rdata/resp)
//   wb_*              writeback result, held stable in DONE until wb_ready
module mem_exec_unit #(
   parameter int unsigned ROB_IDX_W = 5,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 iss_valid,
   output logic                 iss_ready,
   input  logic                 iss_is_store,
   input  logic [2:0]           iss_memop,
   input  logic [ADDR_W-1:0]    iss_base,
   input  logic [ADDR_W-1:0]    iss_imm,
   input  logic [ADDR_W-1:0]    iss_wdata,
   input  logic [ROB_IDX_W-1:0] iss_rob_idx,
   input  logic [4:0]           iss_rd_addr,
   output logic [ADDR_W-1:0]    dmem_addr,
   output logic [3:0]           dmem_rmask,
   output logic [3:0]           dmem_wmask,
   output logic [ADDR_W-1:0]    dmem_wdata,
   input  logic [ADDR_W-1:0]    dmem_rdata,
   input  logic                 dmem_resp,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [ADDR_W-1:0]    wb_data,
   output logic [ROB_IDX_W-1:0] wb_rob_idx,
   output logic [4:0]           wb_rd_addr,
   output logic [ADDR_W-1:0]    wb_mem_addr,
   output logic [3:0]           wb_rmask,
   output logic [3:0]           wb_wmask,
   output logic [ADDR_W-1:0]    wb_rdata,
   output logic [ADDR_W-1:0]    wb_wdata,
   output logic                 wb_misaligned
);

   localparam int unsigned MASK_W = 4;
   localparam int unsigned REG_W  = 5;

   localparam logic [2:0] MOP_B  = 3'd1;
   localparam logic [2:0] MOP_BU = 3'd2;
   localparam logic [2:0] MOP_H  = 3'd3;
   localparam logic [2:0] MOP_HU = 3'd4;
   localparam logic [2:0] MOP_W  = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t state, state_n;

   // Latched op
   logic [ADDR_W-1:0]    ea_q;
   logic [2:0]           memop_q;
   logic                 is_store_q;
   logic [ROB_IDX_W-1:0] rob_q;
   logic [REG_W-1:0]     rd_q;
   logic [MASK_W-1:0]    rmask_q;
   logic [MASK_W-1:0]    wmask_q;
   logic [ADDR_W-1:0]    wdata_q;
   logic [ADDR_W-1:0]    rdata_q;
   logic                 mis_q;

   // Handshake-cycle decode
   logic                 hs_c;
   logic [ADDR_W-1:0]    ea_c;
   logic [1:0]           off_c;
   logic [MASK_W-1:0]    mask_c;
   logic                 mis_c;
   logic                 op_c;
   logic                 go_req_c;

   assign hs_c     = iss_valid & iss_ready & ~flush;
   assign ea_c     = iss_base + iss_imm;
   assign off_c    = ea_c[1:0];
   assign go_req_c = op_c & ~mis_c;

   // Access-size mask and misalignment; encodings 0, 6 and 7 are treated as no access
   always_comb begin
      mask_c = '0;
      mis_c  = 1'b0;
      op_c   = 1'b1;
      case (iss_memop)
         MOP_B, MOP_BU: mask_c = 4'b0001 << off_c;
         MOP_H, MOP_HU: begin
            mask_c = 4'b0011 << off_c;
            mis_c  = off_c[0];
         end
         MOP_W: begin
            mask_c = 4'b1111;
            mis_c  = (off_c != 2'b00);
         end
         default: op_c = 1'b0;
      endcase
      if (mis_c) mask_c = '0;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next state. A request that has gone out is always drained before IDLE.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (hs_c) state_n = go_req_c ? REQ : DONE;
         REQ:   state_n = flush ? DRAIN : WAIT;
         WAIT: begin
            if (dmem_resp)  state_n = flush ? IDLE : DONE;
            else if (flush) state_n = DRAIN;
         end
         DONE:  if (flush || wb_ready) state_n = IDLE;
         DRAIN: if (dmem_resp) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Op capture at handshake; response capture in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ea_q       <= '0;
         memop_q    <= '0;
         is_store_q <= 1'b0;
         rob_q      <= '0;
         rd_q       <= '0;
         rmask_q    <= '0;
         wmask_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         mis_q      <= 1'b0;
      end else if (state == IDLE && hs_c) begin
         ea_q       <= ea_c;
         memop_q    <= iss_memop;
         is_store_q <= iss_is_store;
         rob_q      <= iss_rob_idx;
         rd_q       <= iss_rd_addr;
         rmask_q    <= iss_is_store ? '0 : mask_c;
         wmask_q    <= iss_is_store ? mask_c : '0;
         wdata_q    <= (iss_is_store && go_req_c) ? (iss_wdata << {off_c, 3'b000}) : '0;
         rdata_q    <= '0;
         mis_q      <= mis_c;
      end else if (state == WAIT && dmem_resp) begin
         rdata_q    <= dmem_rdata;
      end
   end

   // Load extract: shift the addressed lane down, then extend
   logic [15:0]       lane;
   logic [ADDR_W-1:0] ext;

   always_comb begin
      lane = 16'(rdata_q >> {ea_q[1:0], 3'b000});
      ext  = '0;
      case (memop_q)
         MOP_B:  ext = {{24{lane[7]}}, lane[7:0]};
         MOP_BU: ext = {24'd0, lane[7:0]};
         MOP_H:  ext = {{16{lane[15]}}, lane};
         MOP_HU: ext = {16'd0, lane};
         MOP_W:  ext = rdata_q;
         default: ext = '0;
      endcase
      if (is_store_q || mis_q) ext = '0;
   end

   // Outputs are decoded from the state register and latched fields only
   logic in_req, in_done;
   assign in_req  = (state == REQ);
   assign in_done = (state == DONE);

   assign iss_ready     = (state == IDLE);
   assign dmem_addr     = in_req ? {ea_q[ADDR_W-1:2], 2'b00} : '0;
   assign dmem_rmask    = in_req ? rmask_q : '0;
   assign dmem_wmask    = in_req ? wmask_q : '0;
   assign dmem_wdata    = in_req ? wdata_q : '0;

   assign wb_valid      = in_done;
   assign wb_data       = in_done ? ext     : '0;
   assign wb_rob_idx    = in_done ? rob_q   : '0;
   assign wb_rd_addr    = in_done ? rd_q    : '0;
   assign wb_mem_addr   = in_done ? ea_q    : '0;
   assign wb_rmask      = in_done ? rmask_q : '0;
   assign wb_wmask      = in_done ? wmask_q : '0;
   assign wb_rdata      = in_done ? rdata_q : '0;
   assign wb_wdata      = in_done ? wdata_q : '0;
   assign wb_misaligned = in_done & mis_q;

endmodule
